// File: rtl/sr_rx_if_pkg.sv
// Shared types and constants for the 3-wire shift-register link receiver.
package sr_rx_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned MAJ_LEN    = 3;

    // True when more than half of the window samples are high.
    function automatic logic majority(input logic [MAJ_LEN-1:0] s);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MAJ_LEN; i++) begin
            ones += 32'(s[i]);
        end
        return ones > (MAJ_LEN / 2);
    endfunction

endpackage

// File: rtl/sr_rx_sync_edge.sv
// Per-line pad synchronizer with rise/fall pulse generation.
// SR_RX_GLITCH_FILT_EN adds a majority filter that rejects single-cycle glitches.
module sr_rx_sync_edge
    import sr_rx_if_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], din};
        end
    end

`ifdef SR_RX_GLITCH_FILT_EN
    logic [MAJ_LEN-2:0] hist;
    logic               filt;

    // Window is the newest synchronized sample plus the previous MAJ_LEN-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            filt <= 1'b0;
        end else begin
            hist <= {hist[MAJ_LEN-3:0], sync[SYNC_DEPTH-1]};
            filt <= majority({hist, sync[SYNC_DEPTH-1]});
        end
    end

    assign lvl = filt;
`else
    assign lvl = sync[SYNC_DEPTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= lvl;
        end
    end

    assign rise_c = lvl & ~s_d;
    assign fall_c = ~lvl & s_d;

endmodule

// File: rtl/sr_rx_if.sv
// 74HC595-style receiver: deserializes MSB-first words, latches on RCLK, emulates the button.
// Build option SR_RX_GLITCH_FILT_EN enables input glitch filtering in sr_rx_sync_edge.
module sr_rx_if
    import sr_rx_if_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned TIMEOUT_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sr_clk,
    input  logic          sr_dat,
    input  logic          sr_rclk,
    input  logic          btn_press,
    output logic          rclk_pd,
    output logic [DW-1:0] out_val,
    output logic          out_stb,
    output logic          frame_err,
    output logic          busy
);

    localparam int unsigned CW      = $clog2(DW) + 1;
    localparam int unsigned TW      = TIMEOUT_LOG2 + 1;
    localparam int unsigned CNT_MAX = 2 * DW - 1;

    logic clk_lvl, clk_rise, clk_fall;
    logic dat_lvl, dat_rise, dat_fall;
    logic rclk_lvl, rclk_rise, rclk_fall;
    logic unused_edges;

    sr_rx_sync_edge u_clk_se (
        .clk(clk), .rst(rst), .din(sr_clk),
        .lvl(clk_lvl), .rise_c(clk_rise), .fall_c(clk_fall)
    );

    sr_rx_sync_edge u_dat_se (
        .clk(clk), .rst(rst), .din(sr_dat),
        .lvl(dat_lvl), .rise_c(dat_rise), .fall_c(dat_fall)
    );

    sr_rx_sync_edge u_rclk_se (
        .clk(clk), .rst(rst), .din(sr_rclk),
        .lvl(rclk_lvl), .rise_c(rclk_rise), .fall_c(rclk_fall)
    );

    assign unused_edges = &{clk_lvl, clk_fall, dat_rise, dat_fall, rclk_lvl};

    state_t        state, state_nxt;
    logic [DW-1:0] shift, shift_nxt, shift_up;
    logic [CW-1:0] bit_cnt, cnt_nxt, cnt_up;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [DW-1:0] val_nxt;
    logic          stb_nxt, err_nxt, do_latch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            out_val   <= '0;
            out_stb   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            rclk_pd   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            tcnt      <= tcnt_nxt;
            out_val   <= val_nxt;
            out_stb   <= stb_nxt;
            frame_err <= err_nxt;
            busy      <= (state_nxt != ST_IDLE);
            rclk_pd   <= btn_press;
        end
    end

    // Shift is resolved before the latch so a coincident RCLK sees the updated word.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        cnt_nxt   = bit_cnt;
        tcnt_nxt  = tcnt;
        val_nxt   = out_val;
        stb_nxt   = 1'b0;
        err_nxt   = 1'b0;
        do_latch  = 1'b0;
        shift_up  = {shift[DW-2:0], dat_lvl};
        cnt_up    = (bit_cnt == CW'(CNT_MAX)) ? bit_cnt : bit_cnt + CW'(1);

        case (state)
            ST_IDLE: begin
                tcnt_nxt = '0;
                if (clk_rise) begin
                    shift_nxt = shift_up;
                    cnt_nxt   = CW'(1);
                    state_nxt = ST_SHIFT;
                end
                do_latch = rclk_rise;
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    shift_nxt = shift_up;
                    cnt_nxt   = cnt_up;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt  = tcnt + TW'(1);
                end
                if (rclk_rise) begin
                    do_latch = 1'b1;
                end else if (!clk_rise && tcnt[TW-1]) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    tcnt_nxt  = '0;
                end
            end
            ST_HOLD: begin
                tcnt_nxt = '0;
                if (rclk_fall) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                tcnt_nxt  = '0;
            end
        endcase

        if (do_latch) begin
            state_nxt = ST_HOLD;
            tcnt_nxt  = '0;
            if (cnt_nxt == CW'(DW)) begin
                val_nxt = shift_nxt;
                stb_nxt = 1'b1;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_rx_if.sv
// Scoreboard bench for sr_rx_if: random and directed frames against a word-level model.
module tb_sr_rx_if;

    localparam int DW = 8;
    localparam int TL = 8;
`ifdef SR_RX_GLITCH_FILT_EN
    localparam int LAT  = 5;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, sr_clk, sr_dat, sr_rclk, btn_press;
    logic          rclk_pd, out_stb, frame_err, busy;
    logic [DW-1:0] out_val;

    sr_rx_if #(.DW(DW), .TIMEOUT_LOG2(TL)) dut (
        .clk(clk), .rst(rst), .sr_clk(sr_clk), .sr_dat(sr_dat), .sr_rclk(sr_rclk),
        .btn_press(btn_press), .rclk_pd(rclk_pd), .out_val(out_val),
        .out_stb(out_stb), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_err;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] exp_val;
    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    int unsigned   t_rise = 0;
    int unsigned   t_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe or error must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (out_stb || frame_err)) begin
            exp_t e;
            check("stb_err_exclusive", 32'(out_stb & frame_err), 32'd0);
            if (frame_err) t_err = cyc;
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({out_stb, frame_err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_is_err", 32'(frame_err), 32'(e.is_err));
                check("out_val", 32'(out_val), 32'(e.val));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Word-level model: a latch is good only when exactly DW clock rises were seen.
    task automatic model_frame(input logic [15:0] data, input int n, input bit glitch);
        logic bits[$];
        logic [DW-1:0] v;
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            if (glitch && !FILT && i != n - 1) bits.push_back(data[i]);
            bits.push_back(data[i]);
        end
        if (bits.size() == DW) begin
            v = '0;
            for (int k = 0; k < DW; k++) v[DW-1-k] = bits[k];
            e = '{is_err: 1'b0, val: v};
            exp_val = v;
        end else begin
            e = '{is_err: 1'b1, val: exp_val};
        end
        sb.push_back(e);
    endtask

    task automatic shift_bits(input logic [15:0] data, input int n, input bit glitch);
        for (int i = n - 1; i >= 0; i--) begin
            sr_dat = data[i];
            if (glitch && i != n - 1) begin
                tick(3);
                sr_clk = 1'b1;
                tick(1);
                sr_clk = 1'b0;
                tick(4);
            end else begin
                tick(8);
            end
            sr_clk = 1'b1;
            t_rise = cyc;
            tick(8);
            sr_clk = 1'b0;
        end
    endtask

    task automatic latch_pulse();
        tick(8);
        sr_rclk = 1'b1;
        tick(8);
        check("busy_in_hold", 32'(busy), 32'd1);
        sr_rclk = 1'b0;
        tick(8);
        check("busy_after_rclk_fall", 32'(busy), 32'd0);
    endtask

    task automatic frame(input logic [15:0] data, input int n, input bit glitch);
        model_frame(data, n, glitch);
        shift_bits(data, n, glitch);
        latch_pulse();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int          n;
        bit          g;

        rst = 1'b1; sr_clk = 1'b0; sr_dat = 1'b0; sr_rclk = 1'b0; btn_press = 1'b0;
        exp_val = '0;
        tick(3);
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_stb", 32'(out_stb), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rclk_pd", 32'(rclk_pd), 32'd0);
        rst = 1'b0;
        tick(2);

        frame(16'h00A5, 8, 1'b0);
        frame(16'h00FF, 5, 1'b0);
        frame(16'h0000, 0, 1'b0);
        frame(16'h1234, 12, 1'b0);

        // Partial word abandoned: error exactly LAT + 2^TL + 1 cycles after the last rise.
        sb.push_back('{is_err: 1'b1, val: exp_val});
        shift_bits(16'h0005, 3, 1'b0);
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        check("timeout_seen", 32'(sb.size()), 32'd0);
        check("timeout_latency", t_err - t_rise, 32'(LAT + (1 << TL) + 1));
        tick(2);
        check("timeout_busy", 32'(busy), 32'd0);
        frame(16'h003C, 8, 1'b0);

        // Reset mid-word discards progress with no event.
        shift_bits(16'h0008, 4, 1'b0);
        tick(1);
        rst = 1'b1;
        #1;
        check("midrst_out_val", 32'(out_val), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_stb_err", 32'({out_stb, frame_err}), 32'd0);
        tick(1);
        rst = 1'b0;
        exp_val = '0;
        tick(2);
        frame(16'h0081, 8, 1'b0);

        btn_press = 1'b1;
        #1 check("btn_not_yet", 32'(rclk_pd), 32'd0);
        tick(1);
        check("btn_pressed", 32'(rclk_pd), 32'd1);
        btn_press = 1'b0;
        #1 check("btn_release_lag", 32'(rclk_pd), 32'd1);
        tick(1);
        check("btn_released", 32'(rclk_pd), 32'd0);

        frame(16'h005A, 8, 1'b1);

        for (int r = 0; r < 25; r++) begin
            d = 16'($urandom);
            n = ($urandom_range(0, 1) == 1) ? DW : int'($urandom_range(0, 12));
            g = ($urandom_range(0, 3) == 0);
            btn_press = 1'($urandom_range(0, 1));
            frame(d, n, g);
        end
        btn_press = 1'b0;

        tick(10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
